// File: rtl/i2c_master_param.sv
// Parametrised I2C master: START, address+RNW, DATA_BYTES data bytes with ACK/NACK handling, STOP.
// Define I2C_MASTER_CLK_STRETCH_EN to let a slave stretch SCL (SCL_IN is otherwise ignored).
module i2c_master_param #(
    parameter int DATA_BYTES = 2,
    parameter int CLK_DIV    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    RNW,
    input  logic [6:0]              I2C_ADDR,
    input  logic [8*DATA_BYTES-1:0] WR_DATA,
    input  logic                    START_STB,
    input  logic                    SDA_IN,
    input  logic                    SCL_IN,
    output logic                    SCL,
    output logic                    SDA_OUT,
    output logic                    SDA_OE,
    output logic [8*DATA_BYTES-1:0] RD_DATA,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    NACK
);
    localparam int DW  = 8 * DATA_BYTES;
    localparam int QW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [QW-1:0]  QLAST     = QW'(CLK_DIV - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(DATA_BYTES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]     r_state;
    logic [QW-1:0]  r_qcnt;
    logic [1:0]     r_phase;
    logic [3:0]     r_bit;
    logic [BCW-1:0] r_byte;
    logic [7:0]     r_shift;
    logic [DW-1:0]  r_wdata;
    logic [DW-1:0]  r_rdata;
    logic [DW-1:0]  r_rd_out;
    logic           r_rnw;
    logic           r_sda_smp;
    logic           r_done;
    logic           r_nack;

    logic w_hold;
    logic w_step;
    logic w_sample;
    logic w_bit_end;
    logic w_last_byte;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    // Freeze the quarter counter while we release SCL high but a slave still holds it low.
    assign w_hold = (r_state != S_IDLE) && r_phase[1] && SCL && !SCL_IN;
`else
    logic w_unused_scl_in;
    assign w_unused_scl_in = SCL_IN;
    assign w_hold          = 1'b0;
`endif

    assign w_step      = (r_qcnt == QLAST) && !w_hold;
    assign w_sample    = w_step && (r_phase == 2'd2);
    assign w_bit_end   = w_step && (r_phase == 2'd3);
    assign w_last_byte = (r_byte == LAST_BYTE);

    assign BUSY    = (r_state != S_IDLE);
    assign DONE    = r_done;
    assign NACK    = r_nack;
    assign RD_DATA = r_rd_out;

    // Bit 8 of each byte slot is the ACK bit.
    always_comb begin
        SCL     = 1'b1;
        SDA_OUT = 1'b1;
        SDA_OE  = 1'b1;
        case (r_state)
            S_START: SDA_OUT = ~r_phase[1];
            S_ADDR, S_WDATA: begin
                SCL = r_phase[1];
                if (r_bit[3]) SDA_OE = 1'b0;
                else          SDA_OUT = r_shift[7];
            end
            S_RDATA: begin
                SCL = r_phase[1];
                if (r_bit[3]) SDA_OUT = w_last_byte;
                else          SDA_OE = 1'b0;
            end
            S_STOP: begin
                SCL     = (r_phase != 2'd0);
                SDA_OUT = (r_phase == 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_qcnt    <= '0;
            r_phase   <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_shift   <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_rd_out  <= '0;
            r_rnw     <= 1'b0;
            r_sda_smp <= 1'b0;
            r_done    <= 1'b0;
            r_nack    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                r_qcnt  <= '0;
                r_phase <= '0;
                r_bit   <= '0;
                r_byte  <= '0;
                if (START_STB) begin
                    r_state <= S_START;
                    r_shift <= {I2C_ADDR, RNW};
                    r_rnw   <= RNW;
                    r_wdata <= WR_DATA;
                    r_rdata <= '0;
                    r_nack  <= 1'b0;
                end
            end else begin
                if (!w_hold) r_qcnt <= (r_qcnt == QLAST) ? '0 : r_qcnt + QW'(1);
                if (w_step)  r_phase <= r_phase + 2'd1;
                if (w_sample) begin
                    r_sda_smp <= SDA_IN;
                    if (r_state == S_RDATA && !r_bit[3]) r_rdata <= {r_rdata[DW-2:0], SDA_IN};
                end
                if (w_bit_end) begin
                    case (r_state)
                        S_START: begin
                            r_state <= S_ADDR;
                            r_bit   <= '0;
                        end
                        S_ADDR, S_WDATA, S_RDATA: begin
                            if (!r_bit[3]) begin
                                r_bit   <= r_bit + 4'd1;
                                r_shift <= {r_shift[6:0], 1'b0};
                            end else begin
                                r_bit <= '0;
                                // A read-data ACK slot is driven by us, so only ADDR/WDATA can abort.
                                if (r_state != S_RDATA && r_sda_smp) begin
                                    r_nack  <= 1'b1;
                                    r_state <= S_STOP;
                                end else if (r_state == S_ADDR) begin
                                    r_byte  <= '0;
                                    r_state <= r_rnw ? S_RDATA : S_WDATA;
                                    r_shift <= r_wdata[DW-1 -: 8];
                                    r_wdata <= r_wdata << 8;
                                end else if (w_last_byte) begin
                                    r_state <= S_STOP;
                                end else begin
                                    r_byte  <= r_byte + BCW'(1);
                                    r_shift <= r_wdata[DW-1 -: 8];
                                    r_wdata <= r_wdata << 8;
                                end
                            end
                        end
                        S_STOP: begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                            if (r_rnw && !r_nack) r_rd_out <= r_rdata;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_param.sv
// Scoreboard bench for i2c_master_param (DATA_BYTES=2, CLK_DIV=1) with a behavioural I2C slave.
module tb_i2c_master_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RNW = 1'b0;
    logic        START_STB = 1'b0;
    logic [6:0]  I2C_ADDR = '0;
    logic [15:0] WR_DATA = '0;
    logic        SDA_IN, SCL_IN;
    logic        SCL, SDA_OUT, SDA_OE, BUSY, DONE, NACK;
    logic [15:0] RD_DATA;
    logic        slv_drv = 1'b1;
    logic        stretch = 1'b0;
    logic        sda_line;

    assign sda_line = SDA_OE ? SDA_OUT : slv_drv;
    assign SDA_IN   = sda_line;
    assign SCL_IN   = SCL & ~stretch;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    localparam int STRETCH_LAT = 126;
`else
    localparam int STRETCH_LAT = 116;
`endif

    i2c_master_param #(.DATA_BYTES(2), .CLK_DIV(1)) dut (
        .clk(clk), .rst(rst), .RNW(RNW), .I2C_ADDR(I2C_ADDR), .WR_DATA(WR_DATA),
        .START_STB(START_STB), .SDA_IN(SDA_IN), .SCL_IN(SCL_IN), .SCL(SCL),
        .SDA_OUT(SDA_OUT), .SDA_OE(SDA_OE), .RD_DATA(RD_DATA), .BUSY(BUSY),
        .DONE(DONE), .NACK(NACK)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          done_cyc;
        logic        nack;
        logic [15:0] rd;
        int          nfr;
        logic [3:0][8:0] oe;
        logic [3:0][8:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic resp[64];
    logic [8:0] f_oe[4];
    logic [8:0] f_val[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_resp(input logic a_ack, input logic [7:0] b1, input logic k1,
                            input logic [7:0] b2, input logic k2);
        for (int i = 0; i < 64; i++) resp[i] = 1'b1;
        resp[8] = a_ack;
        for (int i = 0; i < 8; i++) begin
            resp[9+i]  = b1[7-i];
            resp[18+i] = b2[7-i];
        end
        resp[17] = k1;
        resp[26] = k2;
    endtask

    task automatic wframe(input int i, input logic [7:0] b);
        f_oe[i]  = 9'h1FE;
        f_val[i] = {b, 1'b0};
    endtask

    task automatic rframe(input int i, input logic ack);
        f_oe[i]  = 9'h001;
        f_val[i] = {8'h00, ack};
    endtask

    task automatic issue(input bit sync, input logic rnw, input logic [6:0] addr,
                         input logic [15:0] data, input int lat, input logic nack_e,
                         input logic [15:0] rd_e, input int nfr, input bit push, output int s);
        exp_t e;
        if (sync) @(negedge clk);
        RNW = rnw; I2C_ADDR = addr; WR_DATA = data; START_STB = 1'b1;
        s = cyc + 1;
        if (push) begin
            e.done_cyc = s + lat; e.nack = nack_e; e.rd = rd_e; e.nfr = nfr;
            for (int i = 0; i < 4; i++) begin
                e.oe[i]  = f_oe[i];
                e.val[i] = f_val[i];
            end
            sb.push_back(e);
        end
        @(negedge clk);
        START_STB = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((sb.size() != 0 || BUSY) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", sb.size(), 0);
        check("busy_idle", BUSY, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_scl"}, SCL, 1'b1);
        check({tag, "_sda_out"}, SDA_OUT, 1'b1);
        check({tag, "_sda_oe"}, SDA_OE, 1'b1);
        check({tag, "_busy"}, BUSY, 1'b0);
        check({tag, "_done"}, DONE, 1'b0);
        check({tag, "_nack"}, NACK, 1'b0);
        check({tag, "_rd_data"}, RD_DATA, 16'h0000);
    endtask

    // Bus monitor, slave model and scoreboard consumer.
    int         fr_n = 0, bit_n = 0, bitidx = -1;
    logic [8:0] cur_oe = '0, cur_val = '0;
    logic [8:0] fr_oe[4], fr_val[4];
    logic       prev_scl = 1'b1, prev_sda = 1'b1;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (SCL === 1'b1 && prev_scl && prev_sda && sda_line === 1'b0) begin
                fr_n = 0; bit_n = 0; bitidx = -1; cur_oe = '0; cur_val = '0; slv_drv = 1'b1;
            end
            if (prev_scl && SCL === 1'b0) begin
                bitidx++;
                slv_drv = (bitidx >= 0 && bitidx < 64) ? resp[bitidx] : 1'b1;
            end
            if (!prev_scl && SCL === 1'b1 && BUSY === 1'b1) begin
                cur_oe  = {cur_oe[7:0], SDA_OE};
                cur_val = {cur_val[7:0], SDA_OE & SDA_OUT};
                bit_n++;
                if (bit_n == 9) begin
                    if (fr_n < 4) begin
                        fr_oe[fr_n]  = cur_oe;
                        fr_val[fr_n] = cur_val;
                    end
                    fr_n++;
                    bit_n = 0;
                end
            end
            if (DONE === 1'b1) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got DONE at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("nack", NACK, e.nack);
                    check("rd_data", RD_DATA, e.rd);
                    check("frame_count", fr_n, e.nfr);
                    for (int i = 0; i < e.nfr && i < 4; i++) begin
                        check($sformatf("frame%0d_oe", i), fr_oe[i], e.oe[i]);
                        check($sformatf("frame%0d_val", i), fr_val[i], e.val[i]);
                    end
                end
            end
            prev_scl = (SCL === 1'b1);
            prev_sda = (sda_line === 1'b1);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s, n;
        set_resp(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Plain write, all ACKed.
        wframe(0, 8'hA0); wframe(1, 8'hA5); wframe(2, 8'hC3);
        issue(1, 1'b0, 7'h50, 16'hA5C3, 116, 1'b0, 16'h0000, 3, 1, s);
        drain(300);

        // Address NACK.
        set_resp(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        wframe(0, 8'hA0);
        issue(1, 1'b0, 7'h50, 16'hA5C3, 44, 1'b1, 16'h0000, 1, 1, s);
        drain(300);

        // Read 0x1234 from 0x2A.
        set_resp(1'b0, 8'h12, 1'b0, 8'h34, 1'b0);
        wframe(0, 8'h55); rframe(1, 1'b0); rframe(2, 1'b1);
        issue(1, 1'b1, 7'h2A, 16'h0000, 116, 1'b0, 16'h1234, 3, 1, s);
        drain(300);

        // Second START_STB while busy must be ignored.
        set_resp(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        wframe(0, 8'hA0); wframe(1, 8'h12); wframe(2, 8'h34);
        issue(1, 1'b0, 7'h50, 16'h1234, 116, 1'b0, 16'h1234, 3, 1, s);
        wait_until(s + 40);
        I2C_ADDR = 7'h11; START_STB = 1'b1;
        @(negedge clk);
        START_STB = 1'b0;
        drain(300);

        // Reset in the middle of a write.
        issue(1, 1'b0, 7'h50, 16'hA5C3, 116, 1'b0, 16'h0000, 3, 0, s);
        wait_until(s + 60);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Normal write after the reset.
        wframe(0, 8'h78); wframe(1, 8'h0F); wframe(2, 8'h81);
        issue(1, 1'b0, 7'h3C, 16'h0F81, 116, 1'b0, 16'h0000, 3, 1, s);
        drain(300);

        // NACK on the first data byte.
        set_resp(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        wframe(0, 8'hA0); wframe(1, 8'hFF);
        issue(1, 1'b0, 7'h50, 16'hFF00, 80, 1'b1, 16'h0000, 2, 1, s);
        drain(300);

        // Read 0xBEEF, then an aborted read that must leave RD_DATA alone.
        set_resp(1'b0, 8'hBE, 1'b0, 8'hEF, 1'b0);
        wframe(0, 8'h55); rframe(1, 1'b0); rframe(2, 1'b1);
        issue(1, 1'b1, 7'h2A, 16'h0000, 116, 1'b0, 16'hBEEF, 3, 1, s);
        drain(300);
        set_resp(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        wframe(0, 8'h55);
        issue(1, 1'b1, 7'h2A, 16'h0000, 44, 1'b1, 16'hBEEF, 1, 1, s);
        drain(300);

        // SCL_IN held low for 10 cycles during the first data bit.
        set_resp(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        wframe(0, 8'hA0); wframe(1, 8'hA5); wframe(2, 8'hC3);
        issue(1, 1'b0, 7'h50, 16'hA5C3, STRETCH_LAT, 1'b0, 16'hBEEF, 3, 1, s);
        wait_until(s + 42);
        stretch = 1'b1;
        wait_until(s + 52);
        stretch = 1'b0;
        drain(300);

        // START_STB in the DONE cycle is accepted.
        wframe(0, 8'hA0); wframe(1, 8'h01); wframe(2, 8'h02);
        issue(1, 1'b0, 7'h50, 16'h0102, 116, 1'b0, 16'hBEEF, 3, 1, s);
        n = 0;
        while (DONE !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", DONE, 1'b1);
        wframe(0, 8'hA2); wframe(1, 8'h80); wframe(2, 8'h40);
        issue(0, 1'b0, 7'h51, 16'h8040, 116, 1'b0, 16'hBEEF, 3, 1, s);
        check("busy_after_b2b", BUSY, 1'b1);
        drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
